conv_mxi8tobf16: RTL and testbench

Inverse of the BF16→MXINT8 converter. Accepts one MXINT8 block per handshake: 32 two's-complement 8-bit elements plus a shared E8M0 exponent. Expands the block back to BF16 and streams it out as LANES values per beat over 32/LANES beats, with valid/ready flow control on both sides. Sits on the dequantisation path between MX storage and BF16 compute.

---
 rtl/mx_pkg.sv | 19 +
 rtl/mxi8tobf16_elem.sv | 42 ++++
 rtl/conv_mxi8tobf16.sv | 100 ++++++++++
 tb/tb_conv_mxi8tobf16.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mx_pkg.sv
// Shared constants and types for the MX (microscaling) integer formats and BF16.
package mx_pkg;

    localparam int BLOCK_SIZE       = 32;
    localparam int MX_ELEM_W        = 8;
    localparam int INT8_SCALE_SHIFT = 6;

    localparam logic [15:0] BF16_QNAN = 16'h7FC0;
    localparam logic [7:0]  E8M0_NAN  = 8'hFF;

    typedef logic [15:0]        bf16_t;
    typedef logic signed [7:0]  mxi8_t;

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } conv_state_e;

endpackage

// File: rtl/mxi8tobf16_elem.sv
// Combinational MXINT8 element to BF16 conversion; exact, since an 8-bit
// magnitude always fits in the 1+7 bit BF16 significand.
module mxi8tobf16_elem
    import mx_pkg::*;
(
    input  mxi8_t       x,
    input  logic [7:0]  e,
    output bf16_t       y
);

    logic              sign;
    logic [7:0]        mag;
    logic [2:0]        lead;
    logic [7:0]        aligned;
    logic signed [9:0] be;

    // NOTE: every variable gets a default at the top of always_comb so no path
    // leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        sign    = x[7];
        mag     = x[7] ? (~x + 8'd1) : x;
        lead    = '0;
        for (int i = 0; i < MX_ELEM_W; i++) begin
            if (mag[i]) lead = 3'(i);
        end
        aligned = mag << (3'd7 - lead);
        be      = $signed({2'b00, e}) - 10'(INT8_SCALE_SHIFT) + $signed({7'b0, lead});

        if (e == E8M0_NAN) begin
            y = BF16_QNAN;
        end else if (mag == 8'd0) begin
            y = 16'h0000;
        end else if (be <= 0) begin
            y = {sign, 15'h0000};
        end else if (be >= 255) begin
            y = {sign, 8'hFF, 7'h7F};
        end else begin
            y = {sign, be[7:0], aligned[6:0]};
        end
    end

endmodule

// File: rtl/conv_mxi8tobf16.sv
// MXINT8 block to BF16 expander: accepts one 32-element block per handshake and
// streams it out LANES values per beat with valid/ready on both sides.
module conv_mxi8tobf16
    import mx_pkg::*;
#(
    parameter int BLOCK_SIZE = mx_pkg::BLOCK_SIZE,
    parameter int LANES      = 8
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst,
    input  logic                                 i_mx_valid,
    output logic                                 o_mx_ready,
    input  logic [BLOCK_SIZE-1:0][MX_ELEM_W-1:0] i_mx_vec,
    input  logic [7:0]                           i_mx_exp,
    output logic                                 o_bf16_valid,
    input  logic                                 i_bf16_ready,
    output logic [LANES-1:0][15:0]               o_bf16_vec,
    output logic                                 o_bf16_last
);

    localparam int BEATS = BLOCK_SIZE / LANES;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    conv_state_e                          state;
    logic [CNT_W-1:0]                     beat_cnt;
    logic [CNT_W-1:0]                     next_beat;
    logic [CNT_W-1:0]                     load_beat;
    logic [BLOCK_SIZE-1:0][MX_ELEM_W-1:0] blk_vec;
    logic [7:0]                           blk_exp;
    logic [BLOCK_SIZE-1:0][MX_ELEM_W-1:0] src_vec;
    logic [7:0]                           src_exp;
    logic [BEATS-1:0][LANES-1:0][MX_ELEM_W-1:0] src_beats;
    bf16_t [LANES-1:0]                    conv_beat;
    logic                                 accept;
    logic                                 beat_hs;
    logic                                 last_hs;

    assign beat_hs = o_bf16_valid & i_bf16_ready;
    assign last_hs = beat_hs & o_bf16_last;

    // Ready depends on downstream ready so a new block can land on the final
    // beat's handshake without a bubble.
    assign o_mx_ready = (state == ST_IDLE) |
                        ((state == ST_SEND) & o_bf16_last & i_bf16_ready);
    assign accept     = i_mx_valid & o_mx_ready;

    // A freshly accepted block is converted straight from the input port,
    // since the buffer only updates on the same edge.
    assign next_beat = beat_cnt + 1'b1;
    assign load_beat = accept ? '0 : next_beat;
    assign src_vec   = accept ? i_mx_vec : blk_vec;
    assign src_exp   = accept ? i_mx_exp : blk_exp;
    assign src_beats = src_vec;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        mxi8tobf16_elem u_elem (
            .x (mxi8_t'(src_beats[load_beat][g])),
            .e (src_exp),
            .y (conv_beat[g])
        );
    end

    // NOTE: the block buffer carries no reset; it is only read while in SEND,
    // which is reachable solely through a handshake that overwrites it.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            blk_vec <= i_mx_vec;
            blk_exp <= i_mx_exp;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= ST_IDLE;
            beat_cnt     <= '0;
            o_bf16_valid <= 1'b0;
            o_bf16_last  <= 1'b0;
            o_bf16_vec   <= '0;
        end else if (accept) begin
            state        <= ST_SEND;
            beat_cnt     <= '0;
            o_bf16_valid <= 1'b1;
            o_bf16_last  <= (LAST_BEAT == '0);
            o_bf16_vec   <= conv_beat;
        end else if (last_hs) begin
            state        <= ST_IDLE;
            beat_cnt     <= '0;
            o_bf16_valid <= 1'b0;
            o_bf16_last  <= 1'b0;
        end else if (beat_hs) begin
            beat_cnt     <= next_beat;
            o_bf16_last  <= (next_beat == LAST_BEAT);
            o_bf16_vec   <= conv_beat;
        end
    end

endmodule

// File: tb/tb_conv_mxi8tobf16.sv
// Scoreboard bench for conv_mxi8tobf16: a real-arithmetic reference model fills
// the expected-beat queue, a negedge monitor pops and compares.
module tb_conv_mxi8tobf16;

    localparam int BS    = 32;
    localparam int LANES = 8;
    localparam int BEATS = BS / LANES;

    typedef logic [BS-1:0][7:0] blk_t;
    typedef struct packed {
        logic [LANES*16-1:0] vec;
        logic                last;
    } beat_t;

    logic                   i_clk = 1'b0;
    logic                   i_rst;
    logic                   i_mx_valid;
    logic                   o_mx_ready;
    blk_t                   i_mx_vec;
    logic [7:0]             i_mx_exp;
    logic                   o_bf16_valid;
    logic                   i_bf16_ready;
    logic [LANES-1:0][15:0] o_bf16_vec;
    logic                   o_bf16_last;

    beat_t               exp_q[$];
    int                  n_checks = 0;
    int                  n_fail   = 0;
    int                  n_pops   = 0;
    bit                  hold_prev = 0;
    logic [LANES*16-1:0] hold_vec;
    logic                hold_last;
    bit                  rnd_done;

    always #5 i_clk = ~i_clk;

    conv_mxi8tobf16 #(.BLOCK_SIZE(BS), .LANES(LANES)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_mx_valid   (i_mx_valid),
        .o_mx_ready   (o_mx_ready),
        .i_mx_vec     (i_mx_vec),
        .i_mx_exp     (i_mx_exp),
        .o_bf16_valid (o_bf16_valid),
        .i_bf16_ready (i_bf16_ready),
        .o_bf16_vec   (o_bf16_vec),
        .o_bf16_last  (o_bf16_last)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Value = x * 2^(E-127) * 2^-6, normalised by repeated halving.
    function automatic logic [15:0] ref_elem(input logic signed [7:0] x, input logic [7:0] e);
        real  f;
        int   ue, be, mant;
        logic sgn;
        if (e == 8'hFF) return 16'h7FC0;
        if (x == 0) return 16'h0000;
        sgn = (x < 0);
        f   = sgn ? real'(-int'(x)) : real'(int'(x));
        ue  = int'(e) - 127 - 6;
        while (f >= 2.0) begin
            f  = f / 2.0;
            ue = ue + 1;
        end
        be = ue + 127;
        if (be <= 0) return {sgn, 15'h0000};
        if (be >= 255) return {sgn, 8'hFF, 7'h7F};
        mant = int'((f - 1.0) * 128.0);
        return {sgn, be[7:0], mant[6:0]};
    endfunction

    task automatic push_block(input blk_t blk, input logic [7:0] e);
        beat_t t;
        for (int b = 0; b < BEATS; b++) begin
            for (int k = 0; k < LANES; k++)
                t.vec[k*16 +: 16] = ref_elem(blk[b*LANES + k], e);
            t.last = (b == BEATS - 1);
            exp_q.push_back(t);
        end
    endtask

    task automatic send_block(input blk_t blk, input logic [7:0] e, input bit keep);
        int t   = 0;
        bit acc = 0;
        i_mx_vec   = blk;
        i_mx_exp   = e;
        i_mx_valid = 1'b1;
        while (!acc && t < 200) begin
            @(negedge i_clk);
            acc = o_mx_ready;
            @(posedge i_clk);
            #1;
            t++;
        end
        check("accept_timeout", acc, 1);
        if (acc) begin
            push_block(blk, e);
            check("latency_valid", o_bf16_valid, 1);
        end
        if (!keep) begin
            i_mx_valid = 1'b0;
            for (int i = 0; i < BS; i++) i_mx_vec[i] = 8'($urandom);
            i_mx_exp = 8'($urandom);
        end
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || o_bf16_valid) && t < 500) begin
            @(posedge i_clk);
            #1;
            t++;
        end
        check("drain_timeout", (t < 500), 1);
    endtask

    function automatic blk_t rand_blk();
        blk_t b;
        for (int i = 0; i < BS; i++) b[i] = 8'($urandom);
        return b;
    endfunction

    function automatic logic [7:0] rand_exp();
        logic [7:0] pick [4];
        pick[0] = 8'h00; pick[1] = 8'hFF; pick[2] = 8'hFE; pick[3] = 8'h01;
        if ($urandom_range(0, 7) == 0) return pick[$urandom_range(0, 3)];
        return 8'($urandom);
    endfunction

    // Monitor: scoreboard pops on each beat handshake, stability under stall.
    always @(negedge i_clk) begin
        beat_t t;
        if (i_rst) begin
            exp_q.delete();
            hold_prev = 0;
        end else begin
            if (o_bf16_valid && hold_prev) begin
                check("hold_vec", o_bf16_vec, hold_vec);
                check("hold_last", o_bf16_last, hold_last);
            end
            hold_prev = 0;
            if (o_bf16_valid && i_bf16_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    t = exp_q.pop_front();
                    check("beat_vec", o_bf16_vec, t.vec);
                    check("beat_last", o_bf16_last, t.last);
                    n_pops++;
                end
            end else if (o_bf16_valid) begin
                check("stall_mx_ready", o_mx_ready, 0);
                hold_prev = 1;
                hold_vec  = o_bf16_vec;
                hold_last = o_bf16_last;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        blk_t blk, blk2;
        int   base, t, bubbles;

        i_rst        = 1'b1;
        i_mx_valid   = 1'b0;
        i_bf16_ready = 1'b1;
        i_mx_vec     = '0;
        i_mx_exp     = '0;
        repeat (3) @(posedge i_clk);
        #1;
        check("rst_valid", o_bf16_valid, 0);
        check("rst_last", o_bf16_last, 0);
        check("rst_vec", o_bf16_vec, 0);
        check("rst_mx_ready", o_mx_ready, 1);
        i_rst = 1'b0;

        // Unity scale: 0x40 * 2^-6 = 1.0
        for (int i = 0; i < BS; i++) blk[i] = 8'h40;
        send_block(blk, 8'd127, 0);
        drain();

        blk = rand_blk();
        blk[0] = 8'hC0; blk[1] = 8'h01; blk[2] = 8'h80; blk[3] = 8'h00; blk[4] = 8'h7F;
        send_block(blk, 8'd127, 0);
        drain();

        send_block(rand_blk(), 8'hFF, 0);
        drain();
        for (int i = 0; i < BS; i++) blk[i] = i[0] ? 8'hC0 : 8'h40;
        send_block(blk, 8'h00, 0);
        drain();
        blk = rand_blk();
        for (int i = 0; i < BS; i += 3) blk[i] = 8'h80;
        send_block(blk, 8'd254, 0);
        drain();

        // Backpressure for three cycles mid-block
        send_block(rand_blk(), 8'($urandom_range(100, 150)), 0);
        @(posedge i_clk);
        #1;
        i_bf16_ready = 1'b0;
        repeat (3) begin
            @(posedge i_clk);
            #1;
        end
        i_bf16_ready = 1'b1;
        drain();

        // Back-to-back: no idle cycle between the two blocks
        blk  = rand_blk();
        blk2 = rand_blk();
        bubbles = 0;
        fork
            begin
                send_block(blk, 8'd120, 1);
                send_block(blk2, 8'd130, 0);
            end
            begin
                t = 0;
                do begin
                    @(negedge i_clk);
                    t++;
                end while (!o_bf16_valid && t < 50);
                for (int i = 0; i < 2 * BEATS; i++) begin
                    if (!o_bf16_valid) bubbles++;
                    if (i < 2 * BEATS - 1) @(negedge i_clk);
                end
            end
        join
        check("no_bubble", bubbles, 0);
        drain();

        // Reset while beat 2 is presented
        base = n_pops;
        send_block(rand_blk(), 8'd127, 0);
        t = 0;
        while (n_pops < base + 2 && t < 50) begin
            @(posedge i_clk);
            #1;
            t++;
        end
        check("beat2_timeout", (t < 50), 1);
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        check("midrst_valid", o_bf16_valid, 0);
        check("midrst_mx_ready", o_mx_ready, 1);
        check("midrst_last", o_bf16_last, 0);
        check("midrst_vec", o_bf16_vec, 0);
        i_rst = 1'b0;
        send_block(rand_blk(), 8'd127, 0);
        drain();

        // Randomized blocks under random downstream backpressure
        rnd_done = 0;
        fork
            begin
                for (int n = 0; n < 24; n++)
                    send_block(rand_blk(), rand_exp(), (n < 23) ? bit'($urandom_range(0, 1)) : 1'b0);
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge i_clk);
                    #1;
                    i_bf16_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        i_bf16_ready = 1'b1;
        drain();
        check("queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
